// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and the memory wrappers.
package dmem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ISSUE   = 2'd2,
    CAPTURE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_btn_edge_detect.sv
// Registers the debounced debug button and emits a one-cycle rising-edge pulse.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic armed;

  // A button still held from before reset must be released once before it counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      if (!btn) armed <= 1'b1;
    end
  end

  assign rise = btn & ~btn_q & armed;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, the button-stepped debug
// reader is served within MAX_WAIT cycles by stalling the CPU for one cycle.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_btn,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output arb_state_e        state
);

  // Handshake: cpu_rd/cpu_wr are single-cycle requests; the request is issued
  // in any cycle where cpu_stall=0, otherwise the CPU re-presents it next cycle.

  arb_state_e state_nx;
  logic       pending;
  logic [3:0] wait_cnt;
  logic       btn_rise;
  logic       cpu_req;
  logic       want_read;

  btn_edge_detect u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (dbg_btn),
    .rise (btn_rise)
  );

  assign cpu_req   = cpu_rd | cpu_wr;
  // A fresh edge is honoured in the same cycle it lands to keep idle latency short.
  assign want_read = pending | btn_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (want_read) state_nx = WAIT;
      WAIT:    if (!cpu_req || wait_cnt == 4'(MAX_WAIT)) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = want_read ? WAIT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending   <= 1'b0;
      wait_cnt  <= 4'd0;
      dbg_addr  <= '0;
      dbg_rdata <= '0;
    end else begin
      if (state == ISSUE) begin
        pending  <= btn_rise;
        wait_cnt <= 4'd0;
      end else begin
        if (btn_rise) pending <= 1'b1;
        if (state == WAIT && state_nx == WAIT && wait_cnt != 4'hF)
          wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == CAPTURE) begin
        dbg_rdata <= mem_dout;
        dbg_addr  <= dbg_addr + 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    cpu_stall = 1'b0;
    if (rst) begin
      if (state == ISSUE) begin
        mem_en    = 1'b1;
        mem_addr  = dbg_addr;
        cpu_stall = cpu_req;
      end else begin
        mem_en   = cpu_req;
        mem_we   = cpu_wr;
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
      end
    end
  end

  assign cpu_rdata = mem_dout;
  assign dbg_busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port BRAM.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_btn;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] dbg_addr;
  logic          dbg_busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  arb_state_e    state;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [1024];

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_btn(dbg_btn), .dbg_rdata(dbg_rdata), .dbg_addr(dbg_addr), .dbg_busy(dbg_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with a side port for preloading
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          chk;
    logic [DW-1:0] e_rdata;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic press();
    tick(); dbg_btn = 1'b1;
    tick(); dbg_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      if (!dbg_busy) break;
    end
    check("press_done", dbg_busy, 0);
  endtask

  initial begin
    int busy_seen;
    int stall_cnt, stall_at, k;
    logic prev_granted, prev_chk;
    logic [DW-1:0] prev_rdata, expv;

    rst = 1'b0; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_btn = 0; pre_en = 0; pre_addr = '0; pre_data = '0;

    // reset with button and store held
    cpu_wr = 1'b1; dbg_btn = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_dbg_addr", dbg_addr, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_busy", dbg_busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_state", state, IDLE);
    tick(); rst = 1'b1; cpu_wr = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (dbg_busy) busy_seen++;
    end
    check("held_btn_no_read", busy_seen, 0);
    tick(); dbg_btn = 1'b0;

    // CPU pass-through table
    preload(10'd5, 32'h11111111);
    preload(10'd6, 32'h22222222);
    vecs[0] = '{1'b1, 1'b0, 10'd5, 32'h0,        1'b1, 1'b0, 10'd5, 32'h0,        1'b1, 32'h11111111};
    vecs[1] = '{1'b0, 1'b1, 10'd7, 32'hA5A5A5A5, 1'b1, 1'b1, 10'd7, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 10'd7, 32'h0,        1'b1, 1'b0, 10'd7, 32'h0,        1'b1, 32'hA5A5A5A5};
    vecs[3] = '{1'b1, 1'b1, 10'd6, 32'h3C3C3C3C, 1'b1, 1'b1, 10'd6, 32'h3C3C3C3C, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 10'd6, 32'h0,        1'b1, 1'b0, 10'd6, 32'h0,        1'b1, 32'h3C3C3C3C};
    vecs[5] = '{1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0};
    prev_chk = 1'b0; prev_rdata = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      @(negedge clk);
      if (prev_chk) check($sformatf("vec%0d_rdata", i - 1), cpu_rdata, prev_rdata);
      check($sformatf("vec%0d_en", i), mem_en, vecs[i].e_en);
      check($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_din", i), mem_din, vecs[i].e_din);
      check($sformatf("vec%0d_stall", i), cpu_stall, 0);
      prev_chk = vecs[i].chk; prev_rdata = vecs[i].e_rdata;
    end

    // idle-CPU debug step
    preload(10'd0, 32'hDEADBEEF);
    tick(); dbg_btn = 1'b1;
    @(negedge clk); check("step_c0_stall", cpu_stall, 0);
    tick(); dbg_btn = 1'b0;
    @(negedge clk); check("step_c1_state", state, WAIT);
    tick();
    @(negedge clk);
    check("step_issue_state", state, ISSUE);
    check("step_issue_en", mem_en, 1);
    check("step_issue_we", mem_we, 0);
    check("step_issue_addr", mem_addr, 0);
    check("step_issue_stall", cpu_stall, 0);
    tick();
    @(negedge clk); check("step_c3_state", state, CAPTURE);
    tick();
    @(negedge clk);
    check("step_rdata", dbg_rdata, 32'hDEADBEEF);
    check("step_addr", dbg_addr, 1);
    check("step_busy", dbg_busy, 0);

    // starvation bound with continuous CPU loads
    preload(10'd1, 32'hCAFE0001);
    for (int i = 0; i < 16; i++) preload(10'(100 + i), 32'h1000 + 32'(i));
    stall_cnt = 0; stall_at = -1; k = 0; prev_granted = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      cpu_rd = 1'b1; cpu_addr = 10'(100 + k);
      dbg_btn = (j == 0);
      @(negedge clk);
      if (prev_granted) check($sformatf("starve_load%0d", j), cpu_rdata, exp_q.pop_front());
      if (cpu_stall) begin
        stall_cnt++; stall_at = j;
        check("starve_issue_addr", mem_addr, 1);
        prev_granted = 1'b0;
      end else begin
        exp_q.push_back(32'h1000 + 32'(k));
        k++;
        prev_granted = 1'b1;
      end
    end
    tick(); cpu_rd = 1'b0;
    @(negedge clk);
    if (prev_granted) check("starve_load_last", cpu_rdata, exp_q.pop_front());
    check("starve_stall_cnt", stall_cnt, 1);
    check("starve_stall_at", stall_at, 6);
    check("starve_loads", k, 11);
    check("starve_dbg_rdata", dbg_rdata, 32'hCAFE0001);
    check("starve_dbg_addr", dbg_addr, 2);

    // press during ISSUE, second press during WAIT, store during CAPTURE
    tick(); dbg_btn = 1'b1;
    tick(); dbg_btn = 1'b0;
    @(negedge clk); check("sim_c1_state", state, WAIT);
    tick(); dbg_btn = 1'b1;
    @(negedge clk); check("sim_c2_state", state, ISSUE);
    tick(); dbg_btn = 1'b0; cpu_wr = 1'b1; cpu_addr = 10'd50; cpu_wdata = 32'h77;
    @(negedge clk);
    check("sim_cap_state", state, CAPTURE);
    check("sim_cap_we", mem_we, 1);
    check("sim_cap_addr", mem_addr, 50);
    check("sim_cap_stall", cpu_stall, 0);
    tick(); cpu_wr = 1'b0; dbg_btn = 1'b1;
    @(negedge clk); check("sim_c4_state", state, WAIT);
    tick(); dbg_btn = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("sim_state_idle", state, IDLE);
    check("sim_two_reads", dbg_addr, 4);
    tick(); cpu_rd = 1'b1; cpu_addr = 10'd50;
    tick(); cpu_rd = 1'b0;
    @(negedge clk); check("sim_store_data", cpu_rdata, 32'h77);

    // reset during ISSUE
    tick(); dbg_btn = 1'b1;
    tick(); dbg_btn = 1'b0;
    tick();
    @(negedge clk); check("rmid_issue", state, ISSUE);
    rst = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rmid_state", state, IDLE);
    check("rmid_addr", dbg_addr, 0);
    check("rmid_rdata", dbg_rdata, 0);
    repeat (3) tick();
    @(negedge clk);
    check("rmid_addr_later", dbg_addr, 0);
    check("rmid_rdata_later", dbg_rdata, 0);

    // wrap-around
    preload(10'd1023, 32'd5);
    preload(10'd0, 32'd7);
    for (int i = 0; i < 1023; i++) press();
    check("wrap_pre_addr", dbg_addr, 1023);
    press();
    check("wrap_rdata", dbg_rdata, 5);
    check("wrap_addr", dbg_addr, 0);
    press();
    check("wrap_next_rdata", dbg_rdata, 7);
    check("wrap_next_addr", dbg_addr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data-memory BRAM between two requesters: the CPU datapath (load/store) and a button-stepped debug readout engine that walks memory one word per press.
- The CPU has priority. The debug requester is guaranteed service within MAX_WAIT cycles by stalling the CPU for one cycle.
- Sits between the datapath and the data-memory BRAM, and replaces the ad-hoc button/result address mux.

Parameters:
- ADDR_W, 10, data-memory word-address width.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, maximum cycles a pending debug read may wait while the CPU holds the port (legal range 1..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_rd  in  1  CPU load request (level, this cycle).
- cpu_wr  in  1  CPU store request (level, this cycle).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data, equal to mem_dout.
- cpu_stall  out  1  CPU must hold PC and state this cycle; its request was not issued.
- dbg_btn  in  1  debounced button level.
- dbg_rdata  out  DATA_W  last word captured by the debug engine.
- dbg_addr  out  ADDR_W  address the next debug read will use.
- dbg_busy  out  1  debug read pending or in flight.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data; 1-cycle latency after an enabled read.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; pending=0; wait_cnt=0; btn_q=0.
  - dbg_addr=0; dbg_rdata=0.
  - All outputs are 0 after reset except cpu_rdata, which follows mem_dout.
  - Reset mid-read aborts the read: no capture, no address increment.
- Button handling:
  - btn_q registers dbg_btn.
  - A rising edge (dbg_btn & ~btn_q) sets pending.
  - An edge while pending=1 is dropped; there is one-deep buffering only.
  - An edge during ISSUE or CAPTURE sets pending for the next read.
- States: IDLE, WAIT, ISSUE, CAPTURE.
  - IDLE: pending=1 -> WAIT.
  - WAIT:
    - If no CPU request (cpu_rd|cpu_wr=0), or wait_cnt==MAX_WAIT -> ISSUE.
    - Otherwise wait_cnt increments (saturating) and the state stays WAIT.
  - ISSUE:
    - Debug owns the port: mem_en=1, mem_we=0, mem_addr=dbg_addr.
    - cpu_stall=cpu_rd|cpu_wr.
    - pending clears; wait_cnt clears; -> CAPTURE.
  - CAPTURE:
    - dbg_rdata<=mem_dout; dbg_addr<=dbg_addr+1, wrapping 2^ADDR_W-1 -> 0.
    - -> WAIT if pending, else IDLE.
    - The port belongs to the CPU in this cycle.
- CPU pass-through (every state except ISSUE):
  - mem_en=cpu_rd|cpu_wr; mem_we=cpu_wr; mem_addr=cpu_addr; mem_din=cpu_wdata; cpu_stall=0.
  - If cpu_rd and cpu_wr are both 1, the write wins.
- CPU load data is valid on cpu_rdata one cycle after the granted read. A stalled CPU re-presents its request next cycle.
- dbg_busy=1 in WAIT, ISSUE and CAPTURE.
- Debug latency:
  - Idle CPU: button edge at cycle N -> ISSUE at N+2 -> dbg_rdata updated at N+3 edge.
  - Busy CPU: at most N+2+MAX_WAIT for ISSUE.
- cpu_stall is combinational from state and CPU request only; there is no path from mem_dout.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, ISSUE=2'd2, CAPTURE=2'd3.
  - Default ADDR_W/DATA_W, shared with the memory wrappers.
- One natural sub-module, btn_edge_detect: registers dbg_btn and outputs a one-cycle rising-edge pulse, with synchronous active-low reset.
- Arbiter FSM, wait counter and output muxing stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with dbg_btn=1 and cpu_wr=1.
  - Response: dbg_addr=0, dbg_rdata=0, cpu_stall=0, dbg_busy=0. After release with dbg_btn held high, no read occurs until dbg_btn falls and rises again.
- Idle-CPU step:
  - Stimulus: preload mem[0]=0xDEADBEEF; press once.
  - Response: mem_addr=0 with mem_we=0 in ISSUE; dbg_rdata=0xDEADBEEF three cycles after the edge; dbg_addr=1; cpu_stall never 1.
- Starvation bound:
  - Stimulus: MAX_WAIT=4; CPU issues continuous loads; press.
  - Response: exactly one cycle with cpu_stall=1, occurring 6 cycles after the edge; that CPU load is re-issued next cycle; both results correct.
- Wrap-around:
  - Stimulus: force dbg_addr=1023 via 1023 presses, with mem[1023]=5 and mem[0]=7.
  - Response: 1024th press gives dbg_rdata=5 and dbg_addr=0; next press gives dbg_rdata=7.
- Simultaneous events:
  - Stimulus: press during ISSUE, and a second press while in WAIT.
  - Response: the ISSUE-time press yields one further read. The WAIT-time press is dropped, so the total is exactly 2 reads. CPU store in the CAPTURE cycle is written (mem_we=1) with no stall.
- Reset mid-read:
  - Stimulus: rst=0 during ISSUE.
  - Response: dbg_rdata stays 0, dbg_addr=0, state=IDLE.
